// File: rtl/hlsm_pkg.sv
// Shared definitions for the HLSM Start/Done launcher: widths, default latency,
// controller states and the operand-bus indexing helper.
package hlsm_pkg;

    localparam int HLSM_W       = 16;
    localparam int HLSM_NOPS    = 7;
    localparam int HLSM_LATENCY = 12;

    typedef enum logic [2:0] {
        ST_RECOVER,
        ST_IDLE,
        ST_RUN,
        ST_CHECK,
        ST_HOLD
    } hlsm_state_e;

    // LSB position of operand idx (0 = a) inside the packed In_Ops bus.
    function automatic int hlsm_op_lsb(input int idx, input int w);
        return idx * w;
    endfunction

endpackage

// File: rtl/hlsm_launcher.sv
// Initiator side of the HLSM Start/Done handshake: latches one operand set,
// holds Start for LATENCY edges, checks Done and offers J/L downstream.
module hlsm_launcher
    import hlsm_pkg::*;
#(
    parameter int W       = HLSM_W,
    parameter int LATENCY = HLSM_LATENCY
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  In_Valid,
    output logic                  In_Ready,
    input  logic [HLSM_NOPS*W-1:0] In_Ops,
    output logic signed [W-1:0]   Op_A,
    output logic signed [W-1:0]   Op_B,
    output logic signed [W-1:0]   Op_C,
    output logic signed [W-1:0]   Op_D,
    output logic signed [W-1:0]   Op_E,
    output logic signed [W-1:0]   Op_F,
    output logic signed [W-1:0]   Op_G,
    output logic                  Start,
    output logic                  Hlsm_Rst,
    input  logic                  Done,
    input  logic signed [W-1:0]   J,
    input  logic signed [W-1:0]   L,
    output logic                  Out_Valid,
    input  logic                  Out_Ready,
    output logic signed [W-1:0]   Out_J,
    output logic signed [W-1:0]   Out_L,
    output logic                  Err,
    output logic [7:0]            Err_Count
);

    localparam int CW = $clog2(LATENCY);

    hlsm_state_e                    state_q, state_d;
    logic [CW-1:0]                  cnt_q, cnt_d;
    logic                           start_q, start_d;
    logic                           hrst_q, hrst_d;
    logic                           ovld_q, ovld_d;
    logic [W-1:0]                   oj_q, oj_d;
    logic [W-1:0]                   ol_q, ol_d;
    logic                           err_q, err_d;
    logic [7:0]                     ecnt_q, ecnt_d;
    logic [HLSM_NOPS-1:0][W-1:0]    ops_q, ops_d;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q <= ST_RECOVER;
            cnt_q   <= '0;
            start_q <= 1'b0;
            hrst_q  <= 1'b1;
            ovld_q  <= 1'b0;
            oj_q    <= '0;
            ol_q    <= '0;
            err_q   <= 1'b0;
            ecnt_q  <= '0;
            ops_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            start_q <= start_d;
            hrst_q  <= hrst_d;
            ovld_q  <= ovld_d;
            oj_q    <= oj_d;
            ol_q    <= ol_d;
            err_q   <= err_d;
            ecnt_q  <= ecnt_d;
            ops_q   <= ops_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        start_d = start_q;
        hrst_d  = hrst_q;
        ovld_d  = ovld_q;
        oj_d    = oj_q;
        ol_d    = ol_q;
        err_d   = 1'b0;
        ecnt_d  = ecnt_q;
        ops_d   = ops_q;
        case (state_q)
            ST_RECOVER: begin
                hrst_d  = 1'b0;
                state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (In_Valid) begin
                    for (int i = 0; i < HLSM_NOPS; i++)
                        ops_d[i] = In_Ops[hlsm_op_lsb(i, W) +: W];
                    start_d = 1'b1;
                    cnt_d   = CW'(LATENCY - 1);
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (cnt_q == '0) begin
                    start_d = 1'b0;
                    state_d = ST_CHECK;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_CHECK: begin
                // Anything but a clean 1 on Done counts as a miss; the HLSM is
                // then reset so both sides restart from state 0 together.
                if (Done) begin
                    oj_d    = J;
                    ol_d    = L;
                    ovld_d  = 1'b1;
                    state_d = ST_HOLD;
                end else begin
                    err_d   = 1'b1;
                    hrst_d  = 1'b1;
                    if (ecnt_q != 8'hFF) ecnt_d = ecnt_q + 8'd1;
                    state_d = ST_RECOVER;
                end
            end
            ST_HOLD: begin
                if (Out_Ready) begin
                    ovld_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                start_d = 1'b0;
                hrst_d  = 1'b1;
                state_d = ST_RECOVER;
            end
        endcase
    end

    assign In_Ready  = (state_q == ST_IDLE);
    assign Start     = start_q;
    assign Hlsm_Rst  = hrst_q;
    assign Out_Valid = ovld_q;
    assign Out_J     = oj_q;
    assign Out_L     = ol_q;
    assign Err       = err_q;
    assign Err_Count = ecnt_q;
    assign Op_A      = ops_q[0];
    assign Op_B      = ops_q[1];
    assign Op_C      = ops_q[2];
    assign Op_D      = ops_q[3];
    assign Op_E      = ops_q[4];
    assign Op_F      = ops_q[5];
    assign Op_G      = ops_q[6];

endmodule

// File: tb/tb_hlsm_launcher.sv
// Self-checking bench: HLSM responder, timestamp-based reference model,
// per-cycle compare plus directed literal checks and random traffic.
module tb_hlsm_launcher;
    localparam int W = 16, LAT = 12, NOPS = 7;

    logic Clk = 0, Rst = 1, In_Valid = 0, Out_Ready = 0, Done = 0;
    logic In_Ready, Start, Hlsm_Rst, Out_Valid, Err;
    logic [NOPS*W-1:0] In_Ops = '0;
    logic [W-1:0] Op_A, Op_B, Op_C, Op_D, Op_E, Op_F, Op_G, Out_J, Out_L;
    logic [W-1:0] J = '0, L = '0;
    logic [7:0] Err_Count;
    int tests = 0, fails = 0;
    bit done_en = 1;

    hlsm_launcher #(.W(W), .LATENCY(LAT)) dut (
        .Clk(Clk), .Rst(Rst), .In_Valid(In_Valid), .In_Ready(In_Ready), .In_Ops(In_Ops),
        .Op_A(Op_A), .Op_B(Op_B), .Op_C(Op_C), .Op_D(Op_D), .Op_E(Op_E), .Op_F(Op_F), .Op_G(Op_G),
        .Start(Start), .Hlsm_Rst(Hlsm_Rst), .Done(Done), .J(J), .L(L),
        .Out_Valid(Out_Valid), .Out_Ready(Out_Ready), .Out_J(Out_J), .Out_L(Out_L),
        .Err(Err), .Err_Count(Err_Count)
    );

    always #5 Clk = ~Clk;

    function automatic logic [111:0] pk(input logic [15:0] a, b, c, d, e, f, g);
        return {g, f, e, d, c, b, a};
    endfunction
    function automatic logic [111:0] rops();
        logic [127:0] t;
        t = {$urandom(), $urandom(), $urandom(), $urandom()};
        return t[111:0];
    endfunction
    function automatic logic [15:0] jfun(input logic [111:0] o);
        return (o[15:0] * 16'd17) ^ o[47:32] ^ o[79:64] ^ o[111:96];
    endfunction
    function automatic logic [15:0] lfun(input logic [111:0] o);
        return (o[31:16] * 16'd17) ^ o[63:48] ^ o[95:80];
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: edge index cyc, acceptance edge t0, outcome timestamps.
    int cyc = 0, t0 = -100, idle_from = 1, miss_edge = -1;
    bit busy = 0, holding = 0;
    logic [7:0] m_ecnt = '0;
    logic [15:0] m_j = '0, m_l = '0;
    logic [111:0] m_ops = '0;

    initial forever begin
        @(posedge Clk or negedge Rst);
        if (!Rst) begin
            cyc = 0; t0 = -100; idle_from = 1; miss_edge = -1;
            busy = 0; holding = 0; m_ecnt = '0; m_j = '0; m_l = '0; m_ops = '0;
        end else begin
            if (!busy && cyc >= idle_from && In_Valid) begin
                busy = 1; t0 = cyc + 1; m_ops = In_Ops;
            end else if (busy && !holding && cyc + 1 == t0 + LAT + 1) begin
                if (done_en) begin
                    holding = 1; m_j = jfun(m_ops); m_l = lfun(m_ops);
                end else begin
                    busy = 0; miss_edge = cyc + 1; idle_from = cyc + 2;
                    if (m_ecnt != 8'hFF) m_ecnt = m_ecnt + 8'd1;
                end
            end else if (holding && Out_Ready) begin
                holding = 0; busy = 0; idle_from = cyc + 1;
            end
            cyc++;
        end
    end

    // HLSM responder: Done for one cycle after exactly LAT sampled Start edges.
    int run_n = 0;
    initial forever begin
        @(negedge Clk);
        if (!Rst || Hlsm_Rst) begin
            run_n = 0; Done = 0;
        end else if (Start) begin
            run_n++; Done = 0;
        end else begin
            Done = done_en && run_n == LAT;
            if (Done) begin
                J = jfun({Op_G, Op_F, Op_E, Op_D, Op_C, Op_B, Op_A});
                L = lfun({Op_G, Op_F, Op_E, Op_D, Op_C, Op_B, Op_A});
            end
            run_n = 0;
        end
    end

    initial forever begin
        @(negedge Clk);
        chk("in_ready", In_Ready, !busy && cyc >= idle_from);
        chk("start", Start, busy && !holding && cyc >= t0 && cyc < t0 + LAT);
        chk("hlsm_rst", Hlsm_Rst, cyc == 0 || cyc == miss_edge);
        chk("err", Err, cyc == miss_edge);
        chk("err_count", Err_Count, m_ecnt);
        chk("out_valid", Out_Valid, holding);
        chk("out_j", Out_J, m_j);
        chk("out_l", Out_L, m_l);
        chk("ops", {Op_G, Op_F, Op_E, Op_D, Op_C, Op_B, Op_A}, m_ops);
    end

    task automatic send(input logic [111:0] ops);
        bit ok;
        ok = 0;
        In_Ops = ops; In_Valid = 1;
        for (int i = 0; i < 200 && !ok; i++) begin
            ok = In_Ready;
            @(negedge Clk);
        end
        In_Valid = 0;
        chk("send_accept", ok, 1);
    endtask

    task automatic drain();
        bit ok;
        ok = 0;
        Out_Ready = 1;
        for (int i = 0; i < 200 && !ok; i++) begin
            if (In_Ready) ok = 1;
            else @(negedge Clk);
        end
        Out_Ready = 0;
        chk("drain_idle", ok, 1);
    endtask

    initial begin
        int starts, ovk, opbad, bpbad, errs, hr, ovs, ek, rises, last, badint, lowrun, lowmin;
        bit prev_start, seen;
        #1 Rst = 0;
        repeat (3) @(negedge Clk);
        chk("rst_start", Start, 0); chk("rst_hrst", Hlsm_Rst, 1);
        chk("rst_ovalid", Out_Valid, 0); chk("rst_ecnt", Err_Count, 0);
        Rst = 1;
        chk("rel_hrst", Hlsm_Rst, 1); chk("rel_inready", In_Ready, 0);
        @(negedge Clk);
        chk("idle_hrst", Hlsm_Rst, 0); chk("idle_inready", In_Ready, 1);

        // single run, then backpressure
        send(pk(1, 2, 0, 0, 0, 0, 0));
        starts = 0; ovk = -1; opbad = 0;
        for (int k = 0; k < 14; k++) begin
            if (Start) starts++;
            if (Out_Valid && ovk < 0) ovk = k;
            if (Op_A != 16'd1) opbad++;
            if (k < 13) @(negedge Clk);
        end
        chk("start_cycles", starts, 12); chk("ov_rise", ovk, 13);
        chk("lit_out_j", Out_J, 16'h0011); chk("lit_out_l", Out_L, 16'h0022);
        chk("op_a_stable", opbad, 0);
        In_Ops = pk(16'h0ABC, 3, 0, 0, 0, 0, 0); In_Valid = 1;
        bpbad = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge Clk);
            if (Out_Valid !== 1'b1 || Out_J !== 16'h0011 || Out_L !== 16'h0022 ||
                In_Ready !== 1'b0 || Op_A !== 16'd1) bpbad++;
        end
        chk("bp_hold", bpbad, 0);
        Out_Ready = 1; @(negedge Clk); Out_Ready = 0;
        chk("bp_ready", In_Ready, 1); chk("bp_not_taken", Op_A, 16'd1);
        @(negedge Clk); In_Valid = 0;
        chk("bp_taken", Op_A, 16'h0ABC); chk("bp_start", Start, 1);
        drain();

        // missed Done
        done_en = 0;
        send(pk(5, 6, 7, 8, 9, 10, 11));
        errs = 0; hr = 0; ovs = 0; ek = -1;
        for (int k = 0; k < 20; k++) begin
            if (Err) errs++;
            if (Hlsm_Rst) hr++;
            if (Out_Valid) ovs++;
            if (Err && ek < 0) ek = k;
            @(negedge Clk);
        end
        chk("miss_errs", errs, 1); chk("miss_err_at", ek, 13); chk("miss_hrst", hr, 1);
        chk("miss_ovalid", ovs, 0); chk("miss_ecnt", Err_Count, 1); chk("miss_ready", In_Ready, 1);

        // error counter saturation
        for (int i = 0; i < 260; i++) begin send(rops()); drain(); end
        chk("ecnt_sat", Err_Count, 8'hFF);
        done_en = 1;

        // async reset mid-run
        send(rops());
        repeat (5) @(negedge Clk);
        @(posedge Clk); #2 Rst = 0; #1;
        chk("arst_start", Start, 0); chk("arst_hrst", Hlsm_Rst, 1); chk("arst_ecnt", Err_Count, 0);
        @(negedge Clk); Rst = 1;
        chk("arst_hrst_held", Hlsm_Rst, 1);
        @(negedge Clk);
        chk("arst_hrst_low", Hlsm_Rst, 0); chk("arst_ready", In_Ready, 1);
        send(pk(16'h7FFF, 1, 0, 0, 0, 0, 0));
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (Out_Valid) seen = 1; else @(negedge Clk);
        end
        chk("fresh_valid", seen, 1); chk("fresh_j", Out_J, 16'h7FEF); chk("fresh_l", Out_L, 16'h0011);
        drain();

        // back-to-back issue
        Out_Ready = 1; In_Valid = 1; In_Ops = rops();
        rises = 0; last = -1; badint = 0; lowrun = 0; lowmin = 1000; prev_start = Start;
        for (int k = 0; k < 330 && rises < 20; k++) begin
            @(negedge Clk);
            In_Ops = rops();
            if (Start) begin
                if (!prev_start) begin
                    if (last >= 0 && k - last != 15) badint++;
                    if (rises > 0 && lowrun < lowmin) lowmin = lowrun;
                    last = k; rises++;
                end
                lowrun = 0;
            end else lowrun++;
            prev_start = Start;
        end
        In_Valid = 0;
        chk("b2b_runs", rises, 20); chk("b2b_interval", badint, 0);
        chk("b2b_gap", lowmin >= 2, 1); chk("b2b_ecnt", Err_Count, 0);
        drain();

        // random traffic against the model
        for (int k = 0; k < 1500; k++) begin
            @(negedge Clk);
            if (In_Ready && $urandom_range(0, 3) == 0) done_en = ($urandom_range(0, 1) == 1);
            In_Valid = ($urandom_range(0, 1) == 1);
            Out_Ready = ($urandom_range(0, 2) != 0);
            In_Ops = rops();
        end
        In_Valid = 0;
        drain();
        @(negedge Clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
